// File: rtl/psec5_cfg_pkg.sv
// Shared config-interface definitions: register count, reserved address and the
// PICO deserialiser state type (also imported by the POCI readback mux).
package psec5_cfg_pkg;

    localparam int NUM_REGS = 59;
    localparam logic [7:0] ADDR_RESERVED = 8'd0;

    typedef enum logic {ST_ADDR, ST_DATA} pico_state_t;

    // True when a data byte may land at address a of a bank of n registers.
    function automatic logic addr_legal(input logic [7:0] a, input int n);
        return (a != ADDR_RESERVED) && (int'(a) <= n);
    endfunction

endpackage

// File: rtl/s2p_byte_shifter.sv
// LSB-first serial-to-parallel shifter: collects 8 bits while sel is high and
// flags the edge on which the 8th bit arrives.
module s2p_byte_shifter (
    input  logic       sclk,
    input  logic       rstn,
    input  logic       sel,
    input  logic       pico,
    output logic [7:0] byte_o,
    output logic       byte_done_o
);

    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (!sel) begin
            bit_cnt_d = 3'd0;
        end else begin
            shift_d   = {pico, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            shift_q   <= 8'd0;
            bit_cnt_q <= 3'd0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // The completed byte includes the bit currently on the wire.
    assign byte_o      = {pico, shift_q[7:1]};
    assign byte_done_o = sel && (bit_cnt_q == 3'd7);

endmodule

// File: rtl/pico_s2p_regfile.sv
// PICO write path: first byte of a frame sets the address, following bytes are
// written into the register bank (optionally auto-incrementing the address).
module pico_s2p_regfile
    import psec5_cfg_pkg::*;
#(
    parameter int NUM_REGS = psec5_cfg_pkg::NUM_REGS,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic                  sclk,
    input  logic                  rstn,
    input  logic                  sel,
    input  logic                  pico,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic [7:0]            cur_addr,
    output logic                  wr_en,
    output logic [7:0]            wr_addr,
    output logic [7:0]            wr_data,
    output logic                  addr_err,
    output pico_state_t           dbg_state
);

    logic [7:0]  rx_byte;
    logic        byte_done;
    pico_state_t state_q;
    logic [7:0]  cur_addr_q;
    logic        wr_en_q;
    logic [7:0]  wr_addr_q;
    logic [7:0]  wr_data_q;
    logic        addr_err_q;
    logic        cur_legal;
    logic        do_write;

    s2p_byte_shifter u_shifter (
        .sclk       (sclk),
        .rstn       (rstn),
        .sel        (sel),
        .pico       (pico),
        .byte_o     (rx_byte),
        .byte_done_o(byte_done)
    );

    assign cur_legal = addr_legal(cur_addr_q, NUM_REGS);
    assign do_write  = byte_done && (state_q == ST_DATA) && cur_legal;

    // The address only advances on a committed write, so a burst running off
    // the end parks at NUM_REGS+1 and every further byte is flagged and dropped.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_ADDR;
            cur_addr_q <= 8'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
            addr_err_q <= 1'b0;
        end else if (!sel) begin
            state_q <= ST_ADDR;
            wr_en_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (byte_done) begin
                case (state_q)
                    ST_ADDR: begin
                        cur_addr_q <= rx_byte;
                        state_q    <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (cur_legal) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= cur_addr_q;
                            wr_data_q <= rx_byte;
                            if (AUTO_INC && (cur_addr_q != 8'hFF)) begin
                                cur_addr_q <= cur_addr_q + 8'd1;
                            end
                        end else begin
                            addr_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_ADDR;
                endcase
            end
        end
    end

    for (genvar k = 1; k <= NUM_REGS; k++) begin : g_reg
        logic [7:0] r_q;

        always_ff @(posedge sclk or negedge rstn) begin
            if (!rstn) begin
                r_q <= 8'd0;
            end else if (do_write && (cur_addr_q == 8'(k))) begin
                r_q <= rx_byte;
            end
        end

        assign regs_flat[8*k-1 -: 8] = r_q;
    end

    assign cur_addr  = cur_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign addr_err  = addr_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pico_s2p_regfile.sv
// Directed bench for the PICO write path: table of single-byte frames plus
// hand-written burst, abort, framing-collision, async-reset and readback sequences.
module tb_pico_s2p_regfile;
    import psec5_cfg_pkg::*;

    localparam int NR = psec5_cfg_pkg::NUM_REGS;

    logic              sclk;
    logic              rstn;
    logic              sel;
    logic              pico;
    logic [NR*8-1:0]   regs_flat;
    logic [7:0]        cur_addr;
    logic              wr_en;
    logic [7:0]        wr_addr;
    logic [7:0]        wr_data;
    logic              addr_err;
    pico_state_t       dbg_state;

    int checks;
    int failures;
    int wr_pulses;
    logic [7:0] exp_regs [1:NR];

    pico_s2p_regfile dut (
        .sclk     (sclk),
        .rstn     (rstn),
        .sel      (sel),
        .pico     (pico),
        .regs_flat(regs_flat),
        .cur_addr (cur_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .addr_err (addr_err),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    always @(negedge sclk) begin
        if (wr_en === 1'b1) wr_pulses++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 1; k <= NR; k++) exp_regs[k] = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge sclk);
        rstn = 1'b0;
        sel  = 1'b0;
        pico = 1'b0;
        @(negedge sclk);
        rstn = 1'b1;
        clear_model();
    endtask

    // driver: inputs change on negedge, outputs sampled 1 ns after posedge
    task automatic send_bit(input logic b);
        @(negedge sclk);
        sel  = 1'b1;
        pico = b;
        @(posedge sclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic end_frame();
        @(negedge sclk);
        sel  = 1'b0;
        pico = 1'b0;
        @(posedge sclk);
        #1;
    endtask

    task automatic check_bank(input string tag);
        for (int k = 1; k <= NR; k++) begin
            check($sformatf("%s_reg%0d", tag, k), 32'(regs_flat[8*(k-1) +: 8]), 32'(exp_regs[k]));
        end
    endtask

    typedef struct {
        logic       pre_reset;
        logic [7:0] addr;
        logic [7:0] data;
        logic       exp_wr;
        logic       exp_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int p0;
        logic [7:0] rb;

        checks    = 0;
        failures  = 0;
        wr_pulses = 0;
        rstn      = 1'b0;
        sel       = 1'b0;
        pico      = 1'b0;
        clear_model();

        //          rst   addr   data   wr    err
        vecs[0] = '{1'b0, 8'h05, 8'hA3, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 8'h01, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h3B, 8'hE7, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'h20, 8'h5A, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h05, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 8'h00, 8'hFF, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 8'h80, 8'hFF, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 8'h3C, 8'h12, 1'b0, 1'b1};

        #1;
        check("rst_regs_zero", 32'(regs_flat == '0), 32'd1);
        check("rst_cur_addr", 32'(cur_addr), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_ADDR));
        repeat (2) @(negedge sclk);
        rstn = 1'b1;

        // table-driven single-byte frames
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].pre_reset) do_reset();
            p0 = wr_pulses;
            send_byte(vecs[v].addr);
            check($sformatf("v%0d_state_data", v), 32'(dbg_state), 32'(ST_DATA));
            check($sformatf("v%0d_cur_addr", v), 32'(cur_addr), 32'(vecs[v].addr));
            send_byte(vecs[v].data);
            check($sformatf("v%0d_wr_en", v), 32'(wr_en), 32'(vecs[v].exp_wr));
            check($sformatf("v%0d_addr_err", v), 32'(addr_err), 32'(vecs[v].exp_err));
            if (vecs[v].exp_wr) begin
                check($sformatf("v%0d_wr_addr", v), 32'(wr_addr), 32'(vecs[v].addr));
                check($sformatf("v%0d_wr_data", v), 32'(wr_data), 32'(vecs[v].data));
                exp_regs[vecs[v].addr] = vecs[v].data;
            end
            end_frame();
            check($sformatf("v%0d_wr_en_clr", v), 32'(wr_en), 32'd0);
            check($sformatf("v%0d_state_addr", v), 32'(dbg_state), 32'(ST_ADDR));
            check($sformatf("v%0d_pulses", v), 32'(wr_pulses - p0), 32'(vecs[v].exp_wr));
            check_bank($sformatf("v%0d", v));
        end

        // burst off the end of the bank
        do_reset();
        p0 = wr_pulses;
        send_byte(8'h3A);
        send_byte(8'h11);
        check("burst_wr_addr0", 32'(wr_addr), 32'h3A);
        send_byte(8'h22);
        check("burst_wr_addr1", 32'(wr_addr), 32'h3B);
        check("burst_err_early", 32'(addr_err), 32'd0);
        send_byte(8'h33);
        check("burst_err", 32'(addr_err), 32'd1);
        check("burst_cur_addr", 32'(cur_addr), 32'h3C);
        check("burst_wr_en_drop", 32'(wr_en), 32'd0);
        end_frame();
        exp_regs[58] = 8'h11;
        exp_regs[59] = 8'h22;
        check("burst_pulses", 32'(wr_pulses - p0), 32'd2);
        check_bank("burst");

        // abort mid-byte, then a clean rewrite
        do_reset();
        p0 = wr_pulses;
        send_byte(8'h07);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        end_frame();
        check("abort_err", 32'(addr_err), 32'd0);
        check("abort_pulses", 32'(wr_pulses - p0), 32'd0);
        check_bank("abort");
        send_byte(8'h07);
        send_byte(8'h5C);
        end_frame();
        exp_regs[7] = 8'h5C;
        check_bank("abort_rewrite");

        // sel drops on the edge that would complete the byte
        p0 = wr_pulses;
        send_byte(8'h09);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        end_frame();
        check("collide_state", 32'(dbg_state), 32'(ST_ADDR));
        check("collide_pulses", 32'(wr_pulses - p0), 32'd0);
        check("collide_err", 32'(addr_err), 32'd0);
        check_bank("collide");

        // async reset mid data byte
        do_reset();
        send_byte(8'h03);
        send_byte(8'h44);
        end_frame();
        check("ar_reg3", 32'(regs_flat[8*2 +: 8]), 32'h44);
        send_byte(8'h03);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        @(negedge sclk);
        #2;
        rstn = 1'b0;
        #1;
        check("ar_regs_zero", 32'(regs_flat == '0), 32'd1);
        check("ar_cur_addr", 32'(cur_addr), 32'd0);
        check("ar_wr_addr", 32'(wr_addr), 32'd0);
        check("ar_wr_data", 32'(wr_data), 32'd0);
        check("ar_wr_en", 32'(wr_en), 32'd0);
        check("ar_state", 32'(dbg_state), 32'(ST_ADDR));
        sel = 1'b0;
        @(negedge sclk);
        rstn = 1'b1;
        clear_model();

        // fill every register with its own address, then read back serially
        send_byte(8'h01);
        for (int a = 1; a <= NR; a++) begin
            send_byte(8'(a));
            exp_regs[a] = 8'(a);
        end
        check("fill_cur_addr", 32'(cur_addr), 32'(NR + 1));
        check("fill_err", 32'(addr_err), 32'd0);
        end_frame();
        check_bank("fill");
        for (int a = 1; a <= NR; a++) begin
            send_byte(8'(a));
            end_frame();
            rb = 8'h00;
            for (int b = 0; b < 8; b++) rb = {regs_flat[8*(int'(cur_addr)-1) + b], rb[7:1]};
            check($sformatf("loop_rd%0d", a), 32'(rb), 32'(a));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
